// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared AHB-Lite / APB bridge constants and state encoding
//
// Purpose: common HTRANS/HRESP/HSIZE encodings, bridge address-window defaults
// and the slave response state encoding, shared by the AHB master model, the
// AHB slave front-end and the APB controller FSM.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h8000_0000;
  localparam int          DEF_REGION_LOG2 = 26;
  localparam int          DEF_NUM_SLV     = 3;

  // Two-cycle AHB ERROR response: ERR1 stalls the bus, ERR2 completes it.
  typedef enum logic [1:0] {
    ST_OKAY = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } resp_state_t;

endpackage

// File: rtl/ahb_addr_decode.sv
// rtl/ahb_addr_decode.sv - combinational peripheral select and illegal-transfer flag
//
// Purpose: maps an AHB address-phase address into a one-hot APB peripheral
// select and flags transfers that must receive an ERROR response.
// Ports:
//   haddr    in  address-phase address
//   hsize    in  transfer size
//   active   in  an active (NONSEQ/SEQ) transfer is being presented
//   tempselx out one-hot peripheral select, all zero when unmapped
//   illegal  out active transfer that is unmapped, oversized or misaligned
module ahb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          REGION_LOG2 = DEF_REGION_LOG2,
  parameter int          NUM_SLV     = DEF_NUM_SLV
) (
  input  logic [31:0]        haddr,
  input  logic [2:0]         hsize,
  input  logic               active,
  output logic [NUM_SLV-1:0] tempselx,
  output logic               illegal
);

  logic [31:0] offset;
  logic [31:0] region;
  logic        bad_size;
  logic        bad_align;

  assign offset = haddr - BASE_ADDR;
  assign region = offset >> REGION_LOG2;

  // The below-window check keeps a wrapped subtraction from ever aliasing
  // into a valid region, independent of the window parameters.
  always_comb begin
    tempselx = '0;
    if (haddr >= BASE_ADDR) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        if (region == 32'(i)) begin
          tempselx[i] = 1'b1;
        end
      end
    end
  end

  assign bad_size  = (hsize > HSIZE_WORD);
  assign bad_align = ((hsize == HSIZE_HALF) && haddr[0]) ||
                     ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));

  assign illegal = active && ((tempselx == '0) || bad_size || bad_align);

endmodule

// File: rtl/ahb_slave_if.sv
// rtl/ahb_slave_if.sv - AHB-Lite slave front-end of the AHB2APB bridge
//
// Purpose: pipelines address/data/direction for the APB controller, decodes
// the target peripheral, raises valid for legal transfers and drives the
// AHB response including the two-cycle ERROR sequence.
// Ports:
//   hclk, hresetn          clock, asynchronous active-low reset
//   hwrite, hready_in      AHB direction and bus-level HREADY
//   htrans, hsize, haddr   AHB address phase
//   hwdata                 AHB data-phase write data
//   bridge_ready           APB FSM can accept/complete a transfer
//   prdata                 APB read data
//   valid, tempselx        legal transfer strobe and one-hot peripheral select
//   haddr_1/2, hwdata_1/2  address and write data delayed 1 and 2 beats
//   hwrite_reg, hwrite_reg1 direction delayed 1 and 2 beats
//   hr_readyout, hresp     slave HREADY and response
//   hr_data                read data to the master
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          REGION_LOG2 = DEF_REGION_LOG2,
  parameter int          NUM_SLV     = DEF_NUM_SLV
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hwrite,
  input  logic               hready_in,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hsize,
  input  logic [31:0]        haddr,
  input  logic [31:0]        hwdata,
  input  logic               bridge_ready,
  input  logic [31:0]        prdata,
  output logic               valid,
  output logic [NUM_SLV-1:0] tempselx,
  output logic [31:0]        haddr_1,
  output logic [31:0]        haddr_2,
  output logic [31:0]        hwdata_1,
  output logic [31:0]        hwdata_2,
  output logic               hwrite_reg,
  output logic               hwrite_reg1,
  output logic               hr_readyout,
  output logic [1:0]         hresp,
  output logic [31:0]        hr_data
);

  resp_state_t state_q;
  resp_state_t state_d;
  logic        active;
  logic        illegal;

  assign active = hready_in && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  ahb_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .REGION_LOG2(REGION_LOG2),
    .NUM_SLV    (NUM_SLV)
  ) u_decode (
    .haddr   (haddr),
    .hsize   (hsize),
    .active  (active),
    .tempselx(tempselx),
    .illegal (illegal)
  );

  // hresetn is folded in so no transfer is issued while reset is held.
  assign valid = active && !illegal && (state_q != ST_ERR1) && hresetn;

  assign hr_data = prdata;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr_1     <= '0;
      haddr_2     <= '0;
      hwdata_1    <= '0;
      hwdata_2    <= '0;
      hwrite_reg  <= 1'b0;
      hwrite_reg1 <= 1'b0;
    end else if (hready_in) begin
      haddr_1     <= haddr;
      haddr_2     <= haddr_1;
      hwdata_1    <= hwdata;
      hwdata_2    <= hwdata_1;
      hwrite_reg  <= hwrite;
      hwrite_reg1 <= hwrite_reg;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_OKAY;
    end else begin
      state_q <= state_d;
    end
  end

  // Errors take priority over bridge_ready; once in ERR1/ERR2 the APB side
  // is not consulted for the response.
  always_comb begin
    state_d     = state_q;
    hr_readyout = bridge_ready;
    hresp       = HRESP_OKAY;
    case (state_q)
      ST_OKAY: begin
        if (illegal) state_d = ST_ERR1;
      end
      ST_ERR1: begin
        hr_readyout = 1'b0;
        hresp       = HRESP_ERROR;
        state_d     = ST_ERR2;
      end
      ST_ERR2: begin
        hr_readyout = 1'b1;
        hresp       = HRESP_ERROR;
        state_d     = illegal ? ST_ERR1 : ST_OKAY;
      end
      default: begin
        state_d = ST_OKAY;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb/tb_ahb_slave_if.sv - scoreboard testbench for ahb_slave_if
module tb_ahb_slave_if;
  import ahb_apb_pkg::*;

  logic        hclk;
  logic        hresetn;
  logic        hwrite;
  logic        hready_in;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        bridge_ready;
  logic [31:0] prdata;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] haddr_1, haddr_2, hwdata_1, hwdata_2;
  logic        hwrite_reg, hwrite_reg1;
  logic        hr_readyout;
  logic [1:0]  hresp;
  logic [31:0] hr_data;

  int checks   = 0;
  int failures = 0;

  ahb_slave_if dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hwrite      (hwrite),
    .hready_in   (hready_in),
    .htrans      (htrans),
    .hsize       (hsize),
    .haddr       (haddr),
    .hwdata      (hwdata),
    .bridge_ready(bridge_ready),
    .prdata      (prdata),
    .valid       (valid),
    .tempselx    (tempselx),
    .haddr_1     (haddr_1),
    .haddr_2     (haddr_2),
    .hwdata_1    (hwdata_1),
    .hwdata_2    (hwdata_2),
    .hwrite_reg  (hwrite_reg),
    .hwrite_reg1 (hwrite_reg1),
    .hr_readyout (hr_readyout),
    .hresp       (hresp),
    .hr_data     (hr_data)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    string       name;
    logic        v;
    logic [2:0]  sel;
    logic        rdy;
    logic [1:0]  resp;
    bit          cp;
    logic [31:0] a1, a2, d1, d2;
    logic        w1, w2;
    bit          cd;
    logic [31:0] rd;
  } exp_t;

  exp_t sbq[$];

  localparam logic [1:0] OK  = HRESP_OKAY;
  localparam logic [1:0] ERR = HRESP_ERROR;
  localparam logic [1:0] ID  = HTRANS_IDLE;
  localparam logic [1:0] BZ  = HTRANS_BUSY;
  localparam logic [1:0] NS  = HTRANS_NONSEQ;
  localparam logic [1:0] SQ  = HTRANS_SEQ;

  function automatic exp_t mk(string n, logic v, logic [2:0] s, logic r, logic [1:0] rs);
    exp_t e;
    e.name = n; e.v = v; e.sel = s; e.rdy = r; e.resp = rs;
    e.cp = 1'b0; e.a1 = '0; e.a2 = '0; e.d1 = '0; e.d2 = '0; e.w1 = 1'b0; e.w2 = 1'b0;
    e.cd = 1'b0; e.rd = '0;
    return e;
  endfunction

  function automatic exp_t wp(exp_t ein, logic [31:0] a1, logic [31:0] a2,
                              logic [31:0] d1, logic [31:0] d2, logic w1, logic w2);
    exp_t e;
    e = ein;
    e.cp = 1'b1; e.a1 = a1; e.a2 = a2; e.d1 = d1; e.d2 = d2; e.w1 = w1; e.w2 = w2;
    return e;
  endfunction

  function automatic exp_t wd(exp_t ein, logic [31:0] r);
    exp_t e;
    e = ein;
    e.cd = 1'b1; e.rd = r;
    return e;
  endfunction

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
    end
  endtask

  // Drive one cycle's inputs just after the active edge.
  task automatic cyc(input logic rstn, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wdat, input logic hrdy,
                     input logic br, input logic [31:0] pr);
    @(posedge hclk);
    #1;
    hresetn = rstn; htrans = tr; hwrite = wr; hsize = sz; haddr = a;
    hwdata = wdat; hready_in = hrdy; bridge_ready = br; prdata = pr;
  endtask

  // Monitor: every cycle the slave presents its response; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge hclk);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk(e.name, "valid", 32'(valid), 32'(e.v));
        chk(e.name, "tempselx", 32'(tempselx), 32'(e.sel));
        chk(e.name, "hr_readyout", 32'(hr_readyout), 32'(e.rdy));
        chk(e.name, "hresp", 32'(hresp), 32'(e.resp));
        if (e.cp) begin
          chk(e.name, "haddr_1", haddr_1, e.a1);
          chk(e.name, "haddr_2", haddr_2, e.a2);
          chk(e.name, "hwdata_1", hwdata_1, e.d1);
          chk(e.name, "hwdata_2", hwdata_2, e.d2);
          chk(e.name, "hwrite_reg", 32'(hwrite_reg), 32'(e.w1));
          chk(e.name, "hwrite_reg1", 32'(hwrite_reg1), 32'(e.w2));
        end
        if (e.cd) begin
          chk(e.name, "hr_data", hr_data, e.rd);
        end
      end
    end
  end

  initial begin
    hresetn = 1'b0; htrans = ID; hwrite = 1'b0; hsize = 3'd0; haddr = '0;
    hwdata = '0; hready_in = 1'b1; bridge_ready = 1'b1; prdata = '0;

    // reset state; valid forced low while reset is held
    cyc(0, ID, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("rst_idle", 0, 3'b000, 1, OK), 0, 0, 0, 0, 0, 0));
    cyc(0, NS, 1, 0, 32'h8000_0000, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("rst_valid_forced", 0, 3'b001, 1, OK), 0, 0, 0, 0, 0, 0));

    // 1: single NONSEQ byte write
    cyc(1, NS, 1, 0, 32'h8000_0000, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t1_addr", 1, 3'b001, 1, OK), 0, 0, 0, 0, 0, 0));
    cyc(1, ID, 0, 0, 32'h0, 32'h24, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t1_data", 0, 3'b000, 1, OK), 32'h8000_0000, 0, 0, 0, 1, 0));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t1_after", 0, 3'b000, 1, OK), 0, 32'h8000_0000, 32'h24, 0, 0, 1));

    // 2: 4-beat INCR byte write
    cyc(1, NS, 1, 0, 32'h8400_0000, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t2_b0", 1, 3'b010, 1, OK), 0, 0, 0, 32'h24, 0, 0));
    cyc(1, SQ, 1, 0, 32'h8400_0001, 32'h11, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t2_b1", 1, 3'b010, 1, OK), 32'h8400_0000, 0, 0, 0, 1, 0));
    cyc(1, SQ, 1, 0, 32'h8400_0002, 32'h22, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t2_b2", 1, 3'b010, 1, OK), 32'h8400_0001, 32'h8400_0000, 32'h11, 0, 1, 1));
    cyc(1, SQ, 1, 0, 32'h8400_0003, 32'h33, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t2_b3", 1, 3'b010, 1, OK), 32'h8400_0002, 32'h8400_0001, 32'h22, 32'h11, 1, 1));
    cyc(1, ID, 0, 0, 32'h0, 32'h44, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t2_d3", 0, 3'b000, 1, OK), 32'h8400_0003, 32'h8400_0002, 32'h33, 32'h22, 1, 1));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t2_after", 0, 3'b000, 1, OK), 0, 32'h8400_0003, 32'h44, 32'h33, 0, 1));

    // 3: word read with two wait states from the bridge
    cyc(1, NS, 0, 2, 32'h8800_0004, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t3_addr", 1, 3'b100, 1, OK), 0, 0, 0, 32'h44, 0, 0));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 0, 0, 32'hDEAD_BEEF);
    sbq.push_back(wp(mk("t3_wait0", 0, 3'b000, 0, OK), 32'h8800_0004, 0, 0, 0, 0, 0));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 0, 0, 32'hDEAD_BEEF);
    sbq.push_back(wp(mk("t3_wait1", 0, 3'b000, 0, OK), 32'h8800_0004, 0, 0, 0, 0, 0));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 1, 1, 32'hDEAD_BEEF);
    sbq.push_back(wd(wp(mk("t3_done", 0, 3'b000, 1, OK), 32'h8800_0004, 0, 0, 0, 0, 0), 32'hDEAD_BEEF));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t3_after", 0, 3'b000, 1, OK), 0, 32'h8800_0004, 0, 0, 0, 0));

    // 4: unmapped region
    cyc(1, NS, 0, 2, 32'h8C00_0000, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t4_unmapped", 0, 3'b000, 1, OK), 0, 0, 0, 0, 0, 0));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
    sbq.push_back(wp(mk("t4_err1", 0, 3'b000, 0, ERR), 32'h8C00_0000, 0, 0, 0, 0, 0));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t4_err2", 0, 3'b000, 1, ERR), 32'h8C00_0000, 0, 0, 0, 0, 0));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    sbq.push_back(mk("t4_okay", 0, 3'b000, 1, OK));

    // 5a: misaligned word, legal NONSEQ in ERR2 with bridge_ready low
    cyc(1, NS, 1, 2, 32'h8000_0002, 32'h0, 1, 1, 32'h0);
    sbq.push_back(mk("t5a_misalign", 0, 3'b001, 1, OK));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 0, 1, 32'h0);
    sbq.push_back(mk("t5a_err1", 0, 3'b000, 0, ERR));
    cyc(1, NS, 0, 0, 32'h8000_0000, 32'h0, 1, 0, 32'h0);
    sbq.push_back(mk("t5a_err2_legal", 1, 3'b001, 1, ERR));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    sbq.push_back(mk("t5a_okay", 0, 3'b000, 1, OK));

    // 5b: hsize 3 with bridge_ready low; legal beat in ERR1 is gated
    cyc(1, NS, 0, 3, 32'h8000_0000, 32'h0, 1, 0, 32'h0);
    sbq.push_back(mk("t5b_hsize3", 0, 3'b001, 0, OK));
    cyc(1, NS, 0, 0, 32'h8400_0000, 32'h0, 1, 1, 32'h0);
    sbq.push_back(mk("t5b_err1_gate", 0, 3'b010, 0, ERR));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    sbq.push_back(mk("t5b_err2", 0, 3'b000, 1, ERR));
    cyc(1, ID, 0, 0, 32'h0, 32'h0, 1, 1, 32'h0);
    sbq.push_back(mk("t5b_okay", 0, 3'b000, 1, OK));

    // 5c: halfword alignment, then 6: reset asserted during ERR1
    cyc(1, NS, 0, 1, 32'h8000_0002, 32'h0, 1, 1, 32'h0);
    sbq.push_back(mk("t5c_half_ok", 1, 3'b001, 1, OK));
    cyc(1, NS, 0, 1, 32'h8000_0001, 32'h0, 1, 1, 32'h0);
    sbq.push_back(mk("t5c_half_bad", 0, 3'b001, 1, OK));
    cyc(0, NS, 0, 0, 32'h8000_0000, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t6_rst_in_err1", 0, 3'b001, 1, OK), 0, 0, 0, 0, 0, 0));

    // 6: BUSY after release never raises valid or an error
    cyc(1, BZ, 0, 0, 32'h8000_0000, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t6_busy0", 0, 3'b001, 1, OK), 0, 0, 0, 0, 0, 0));
    cyc(1, BZ, 1, 0, 32'h8400_0000, 32'h5, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t6_busy1", 0, 3'b010, 1, OK), 32'h8000_0000, 0, 0, 0, 0, 0));
    cyc(1, BZ, 0, 3, 32'h9000_0000, 32'h0, 1, 1, 32'h0);
    sbq.push_back(wp(mk("t6_busy_odd", 0, 3'b000, 1, OK), 32'h8400_0000, 32'h8000_0000, 32'h5, 0, 1, 0));

    // window edges
    cyc(1, ID, 0, 0, 32'h8BFF_FFFF, 32'h0, 1, 1, 32'h0);
    sbq.push_back(mk("edge_top", 0, 3'b100, 1, OK));
    cyc(1, ID, 0, 0, 32'h7FFF_FFFF, 32'h0, 1, 1, 32'h0);
    sbq.push_back(mk("edge_below", 0, 3'b000, 1, OK));

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge hclk);
    @(posedge hclk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
AHB-Lite slave front-end of the AHB2APB bridge. It sits directly downstream of the AHB master and upstream of the APB controller FSM.
- Pipelines address, write data and direction so the APB side sees address phase and data phase aligned.
- Decodes the target APB peripheral and raises valid for each legal transfer.
- Returns hr_readyout, hresp and hr_data to the master, including the two-cycle AHB ERROR response for illegal transfers.

Parameters:
BASE_ADDR, 32'h8000_0000, start of bridge address window.
REGION_LOG2, 26, log2 of bytes per peripheral region (64 MiB).
NUM_SLV, 3, number of APB peripherals; fixed at 3 for this release.

Ports:
hclk  in  1  bus clock
hresetn  in  1  asynchronous active-low reset
hwrite  in  1  1 = write, 0 = read
hready_in  in  1  bus-level HREADY; address/data phase advances when 1
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hsize  in  3  0 byte, 1 halfword, 2 word; 3..7 illegal
haddr  in  32  address-phase address
hwdata  in  32  data-phase write data
bridge_ready  in  1  APB FSM can accept or complete a transfer
prdata  in  32  read data from the APB side
valid  out  1  legal active transfer in the current address phase
tempselx  out  3  one-hot peripheral select
haddr_1, haddr_2  out  32 each  address delayed 1 and 2 accepted beats
hwdata_1, hwdata_2  out  32 each  write data delayed 1 and 2 accepted beats
hwrite_reg, hwrite_reg1  out  1 each  hwrite delayed 1 and 2 accepted beats
hr_readyout  out  1  slave HREADY
hresp  out  2  00 OKAY, 01 ERROR
hr_data  out  32  read data to the master

Behaviour:
- Clocking and reset: single clock hclk; asynchronous active-low reset hresetn.
- On reset, all pipeline registers = 0 and the state machine = OKAY.
- Decode (combinational):
  - active = hready_in & htrans[1].
  - region index = (haddr - BASE_ADDR) >> REGION_LOG2.
  - Index 0/1/2 gives tempselx = 001/010/100; any other address, including below BASE_ADDR, gives tempselx = 000.
- illegal = active & (tempselx == 0 | hsize > 2 | (hsize == 1 & haddr[0]) | (hsize == 2 & haddr[1:0] != 0)).
- valid = active & !illegal & state != ERR1. It is forced to 0 while hresetn = 0.
- BUSY (01) and IDLE (00) never raise valid or an error; they still advance the pipeline.
- Pipeline: on posedge hclk with hready_in = 1, shift haddr -> haddr_1 -> haddr_2, hwdata -> hwdata_1 -> hwdata_2, and hwrite -> hwrite_reg -> hwrite_reg1. With hready_in = 0, all pipeline registers hold.
- State machine, states OKAY, ERR1, ERR2:
  - OKAY: hr_readyout = bridge_ready, hresp = 00. If illegal, go to ERR1; otherwise stay.
  - ERR1: hr_readyout = 0, hresp = 01. Always go to ERR2.
  - ERR2: hr_readyout = 1, hresp = 01. Decode is evaluated normally. If illegal, go to ERR1, otherwise go to OKAY; a legal transfer here raises valid.
- hr_data = prdata, combinational pass-through. The master samples it only when hr_readyout = 1.
- Simultaneous events:
  - Illegal transfer with bridge_ready = 0: the error takes priority, so ERR1 is entered and no valid is issued.
  - bridge_ready is ignored in ERR1/ERR2.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). No partial error is completed.

Decomposition:
- Shared package ahb_apb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/ERROR
  - HSIZE_BYTE/HALF/WORD
  - BASE_ADDR and REGION_LOG2 defaults
  - the OKAY/ERR1/ERR2 state encoding
- The master, this block and the APB FSM all use this package.
- One natural sub-module: ahb_addr_decode (combinational: tempselx plus the illegal flag).

Test Plan:
1. Reset, then single NONSEQ write: haddr = 8000_0000, hsize = 0, hwdata = 24, bridge_ready = 1 -> valid = 1 and tempselx = 001 in the address cycle; next edge haddr_1 = 8000_0000, hwrite_reg = 1; following edge hwdata_1 = 24.
2. 4-beat INCR byte write from 8400_0000 (NONSEQ, then SEQ x3) -> valid = 1 every beat, tempselx = 010, haddr_2 lags haddr by exactly 2 edges; hresp = 00 throughout.
3. Read at 8800_0004, hsize = 2, prdata = DEAD_BEEF, bridge_ready held 0 for 2 cycles -> hr_readyout = 0 for 2 cycles with the pipeline frozen, then hr_readyout = 1 and hr_data = DEAD_BEEF.
4. Access to 8C00_0000 (unmapped) -> tempselx = 000, valid = 0, next cycle hr_readyout = 0 / hresp = 01, then hr_readyout = 1 / hresp = 01, then OKAY.
5. Misaligned word access at 8000_0002 (hsize = 2), and separately hsize = 3 at 8000_0000 -> each produces the two-cycle ERROR; a legal NONSEQ issued in the ERR2 cycle raises valid and returns to OKAY.
6. Assert hresetn = 0 during ERR1 -> hresp = 00 immediately, hr_readyout follows bridge_ready, all pipeline outputs = 0; BUSY transfers after release never raise valid.
